mole_field_scorer: RTL

MOLE_FIELD_SCORER -- requirements
Module: mole_field_scorer

---
 rtl/mole_field_scorer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mole_field_scorer.sv
// Whack-a-mole field: N_MOLES independent rise/up/fall moles sharing step strobes,
// with saturating BCD totals of scored hits and started rises.
module mole_field_scorer #(
  parameter int N_MOLES    = 8,
  parameter int HW         = 5,
  parameter int H_MAX      = 20,
  parameter int WAIT_TICKS = 4,
  parameter int DIGITS     = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    rl_tick,
  input  logic                    wait_tick,
  input  logic [N_MOLES-1:0]      go,
  input  logic [N_MOLES-1:0]      mole_hit,
  output logic [N_MOLES*HW-1:0]   Mheight,
  output logic [N_MOLES-1:0]      hiding,
  output logic [4*DIGITS-1:0]     totalScore,
  output logic [4*DIGITS-1:0]     totalRise,
  output logic                    score_sat,
  output logic                    rise_sat,
  output logic [2*N_MOLES-1:0]    mole_state
);

  localparam int CW = $clog2(N_MOLES + 1);
  localparam logic [HW-1:0] H_TOP = HW'(H_MAX);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TICKS - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    HIDE = 2'd0,
    RISE = 2'd1,
    UP   = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t          state_q  [N_MOLES];
  state_t          state_d  [N_MOLES];
  logic [HW-1:0]   height_q [N_MOLES];
  logic [HW-1:0]   height_d [N_MOLES];
  logic [7:0]      wait_q   [N_MOLES];
  logic [7:0]      wait_d   [N_MOLES];
  logic [N_MOLES-1:0] scored_q, scored_d;
  logic [N_MOLES-1:0] hit_prev_q, hit_edge, hit_ok, rise_start;
  logic [N_MOLES-1:0] hiding_q, hiding_d;
  logic [CW-1:0]      score_inc, rise_inc;
  logic [4*DIGITS:0]  score_sum, rise_sum;

  function automatic logic [CW-1:0] popcnt(input logic [N_MOLES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_MOLES; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Ripple decimal add of a small binary increment; MSB of the result is the carry out.
  function automatic logic [4*DIGITS:0] bcd_add(input logic [4*DIGITS-1:0] a,
                                                 input logic [CW-1:0] inc);
    logic [4*DIGITS-1:0] r;
    int carry;
    int s;
    r = a;
    carry = int'(inc);
    for (int d = 0; d < DIGITS; d++) begin
      s = int'(a[4*d +: 4]) + carry;
      r[4*d +: 4] = 4'(s % 10);
      carry = s / 10;
    end
    return {carry != 0, r};
  endfunction

  always_comb begin
    hit_edge = mole_hit & ~hit_prev_q;
    for (int i = 0; i < N_MOLES; i++) begin
      state_d[i]    = state_q[i];
      height_d[i]   = height_q[i];
      wait_d[i]     = wait_q[i];
      scored_d[i]   = scored_q[i];
      rise_start[i] = 1'b0;
      hit_ok[i]     = hit_edge[i] && (state_q[i] != HIDE) && !scored_q[i];
      if (hit_ok[i]) scored_d[i] = 1'b1;
      case (state_q[i])
        HIDE: begin
          height_d[i] = '0;
          wait_d[i]   = '0;
          scored_d[i] = 1'b0;
          if (go[i]) begin
            state_d[i]    = RISE;
            rise_start[i] = 1'b1;
          end
        end
        RISE: begin
          // The height step still lands when a hit arrives in the same cycle.
          if (rl_tick && height_q[i] < H_TOP) height_d[i] = height_q[i] + 1'b1;
          if (hit_ok[i]) begin
            state_d[i] = FALL;
          end else if (rl_tick && height_q[i] >= H_TOP - 1'b1) begin
            state_d[i] = UP;
            wait_d[i]  = '0;
          end
        end
        UP: begin
          if (hit_ok[i]) begin
            state_d[i] = FALL;
          end else if (wait_tick) begin
            if (wait_q[i] == WAIT_LAST) state_d[i] = FALL;
            else wait_d[i] = wait_q[i] + 1'b1;
          end
        end
        FALL: begin
          // A hit in FALL freezes the height for that cycle.
          if (!hit_ok[i] && rl_tick) begin
            if (height_q[i] <= 1) begin
              height_d[i] = '0;
              state_d[i]  = HIDE;
            end else begin
              height_d[i] = height_q[i] - 1'b1;
            end
          end
        end
        default: state_d[i] = HIDE;
      endcase
      hiding_d[i] = (state_d[i] == HIDE);
    end
    score_inc = popcnt(hit_ok);
    rise_inc  = popcnt(rise_start);
    score_sum = bcd_add(totalScore, score_inc);
    rise_sum  = bcd_add(totalRise, rise_inc);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_MOLES; i++) begin
        state_q[i]  <= HIDE;
        height_q[i] <= '0;
        wait_q[i]   <= '0;
      end
      scored_q   <= '0;
      hit_prev_q <= '0;
      hiding_q   <= '1;
      totalScore <= '0;
      totalRise  <= '0;
      score_sat  <= 1'b0;
      rise_sat   <= 1'b0;
    end else begin
      for (int i = 0; i < N_MOLES; i++) begin
        state_q[i]  <= state_d[i];
        height_q[i] <= height_d[i];
        wait_q[i]   <= wait_d[i];
      end
      scored_q   <= scored_d;
      hit_prev_q <= mole_hit;
      hiding_q   <= hiding_d;
      if (score_sum[4*DIGITS]) begin
        totalScore <= ALL_NINES;
        score_sat  <= 1'b1;
      end else begin
        totalScore <= score_sum[4*DIGITS-1:0];
      end
      if (rise_sum[4*DIGITS]) begin
        totalRise <= ALL_NINES;
        rise_sat  <= 1'b1;
      end else begin
        totalRise <= rise_sum[4*DIGITS-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_MOLES; i++) begin
      Mheight[i*HW +: HW] = height_q[i];
      mole_state[2*i +: 2] = state_q[i];
    end
  end

  assign hiding = hiding_q;

endmodule
